// File: rtl/control_unit_if.sv
// Handshake and control bus between the control unit and its datapath.
// The master side drives run/ir/mem_done; the slave (control unit) drives the selects.
interface control_unit_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_done;

  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic        Gra, Grb, Grc;
  logic        IncPC, Read, Write;
  logic        ADD, SUB, AND, OR;
  logic        halted;
  logic [3:0]  state;
  logic [15:0] instr_count;

  modport master (
    output run, ir, mem_done,
    input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    input  Gra, Grb, Grc, IncPC, Read, Write,
    input  ADD, SUB, AND, OR, halted, state, instr_count
  );

  modport slave (
    input  run, ir, mem_done,
    output PCout, Zlowout, MDRout, Cout, BAout, Rout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    output Gra, Grb, Grc, IncPC, Read, Write,
    output ADD, SUB, AND, OR, halted, state, instr_count
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch (T0-T3), opcode-specific execute (T4-T8), HALT.
// All control outputs decode only state_q and op_q.
module control_unit (
  input  logic          clk,
  input  logic          clear,
  control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_T8   = 4'd9,
    S_HALT = 4'd10
  } state_e;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        retire_s;
  logic        is_alu_s;
  logic        is_mem_s;
  logic        unused_ir_s;

  function automatic logic op_valid(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR: op_valid = 1'b1;
      default:                                              op_valid = 1'b0;
    endcase
  endfunction

  // Register fields are consumed by the datapath, not by this block.
  assign unused_ir_s = ^bus.ir[26:0];

  assign is_alu_s = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                    (op_q == OP_AND) || (op_q == OP_OR);
  assign is_mem_s = (op_q == OP_LD) || (op_q == OP_ST);

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= S_IDLE;
      op_q          <= 5'd0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state logic; mem_done only matters in the three memory-wait states.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_T0;
        else         state_d = S_IDLE;
      end
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: begin
        if (bus.mem_done) state_d = S_T3;
        else              state_d = S_T2;
      end
      S_T3: begin
        op_d = bus.ir[31:27];
        if (op_valid(bus.ir[31:27])) state_d = S_T4;
        else                         state_d = S_HALT;
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = S_T6;
      S_T6: begin
        if (is_mem_s) begin
          state_d = S_T7;
        end else begin
          state_d  = S_T0;
          retire_s = 1'b1;
        end
      end
      S_T7: begin
        if ((op_q == OP_ST) || bus.mem_done) state_d = S_T8;
        else                                 state_d = S_T7;
      end
      S_T8: begin
        if ((op_q == OP_LD) || bus.mem_done) begin
          state_d  = S_T0;
          retire_s = 1'b1;
        end else begin
          state_d = S_T8;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    instr_count_d = retire_s ? (instr_count_q + 16'd1) : instr_count_q;
  end

  // Moore output decode.
  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
    bus.Cout  = 1'b0; bus.BAout   = 1'b0; bus.Rout   = 1'b0;
    bus.MARin = 1'b0; bus.Zin     = 1'b0; bus.PCin   = 1'b0;
    bus.MDRin = 1'b0; bus.IRin    = 1'b0; bus.Yin    = 1'b0;
    bus.Rin   = 1'b0; bus.Gra     = 1'b0; bus.Grb    = 1'b0;
    bus.Grc   = 1'b0; bus.IncPC   = 1'b0; bus.Read   = 1'b0;
    bus.Write = 1'b0; bus.ADD     = 1'b0; bus.SUB    = 1'b0;
    bus.AND   = 1'b0; bus.OR      = 1'b0;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1;
      end
      S_T2: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T3: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T4: begin
        bus.Grb = 1'b1;
        bus.Yin = 1'b1;
        if (is_alu_s) bus.Rout  = 1'b1;
        else          bus.BAout = 1'b1;
      end
      S_T5: begin
        bus.Zin = 1'b1;
        if (is_alu_s) begin
          bus.Grc  = 1'b1;
          bus.Rout = 1'b1;
          case (op_q)
            OP_SUB:  bus.SUB = 1'b1;
            OP_AND:  bus.AND = 1'b1;
            OP_OR:   bus.OR  = 1'b1;
            default: bus.ADD = 1'b1;
          endcase
        end else begin
          bus.Cout = 1'b1;
          bus.ADD  = 1'b1;
        end
      end
      S_T6: begin
        bus.Zlowout = 1'b1;
        if (is_mem_s) begin
          bus.MARin = 1'b1;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end
      end
      S_T7: begin
        bus.MDRin = 1'b1;
        if (op_q == OP_ST) begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
        end else begin
          bus.Read = 1'b1;
        end
      end
      S_T8: begin
        if (op_q == OP_ST) begin
          bus.Write = 1'b1;
        end else begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
        end
      end
      default: begin
        bus.PCout = 1'b0;
      end
    endcase
  end

  assign bus.halted      = (state_q == S_HALT);
  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: fetch/execute sequences, memory waits,
// asynchronous clear and HALT behaviour.
module tb_control_unit;

  logic clk;
  logic clear;
  int   errors;
  int   checks;

  control_unit_if bus ();

  control_unit u_dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [22:0] M_PCOUT   = 23'd1 << 22;
  localparam logic [22:0] M_ZLOWOUT = 23'd1 << 21;
  localparam logic [22:0] M_MDROUT  = 23'd1 << 20;
  localparam logic [22:0] M_COUT    = 23'd1 << 19;
  localparam logic [22:0] M_BAOUT   = 23'd1 << 18;
  localparam logic [22:0] M_ROUT    = 23'd1 << 17;
  localparam logic [22:0] M_MARIN   = 23'd1 << 16;
  localparam logic [22:0] M_ZIN     = 23'd1 << 15;
  localparam logic [22:0] M_PCIN    = 23'd1 << 14;
  localparam logic [22:0] M_MDRIN   = 23'd1 << 13;
  localparam logic [22:0] M_IRIN    = 23'd1 << 12;
  localparam logic [22:0] M_YIN     = 23'd1 << 11;
  localparam logic [22:0] M_RIN     = 23'd1 << 10;
  localparam logic [22:0] M_GRA     = 23'd1 << 9;
  localparam logic [22:0] M_GRB     = 23'd1 << 8;
  localparam logic [22:0] M_GRC     = 23'd1 << 7;
  localparam logic [22:0] M_INCPC   = 23'd1 << 6;
  localparam logic [22:0] M_READ    = 23'd1 << 5;
  localparam logic [22:0] M_WRITE   = 23'd1 << 4;
  localparam logic [22:0] M_ADD     = 23'd1 << 3;
  localparam logic [22:0] M_SUB     = 23'd1 << 2;
  localparam logic [22:0] M_AND     = 23'd1 << 1;
  localparam logic [22:0] M_OR      = 23'd1 << 0;

  function automatic logic [22:0] ctrl_vec();
    return {bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.BAout, bus.Rout,
            bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.Rin,
            bus.Gra, bus.Grb, bus.Grc, bus.IncPC, bus.Read, bus.Write,
            bus.ADD, bus.SUB, bus.AND, bus.OR};
  endfunction

  // Pulse clear between falling edges; returns on a falling edge with the DUT idle.
  task automatic do_clear();
    @(negedge clk);
    clear        = 1'b1;
    bus.run      = 1'b0;
    bus.mem_done = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.state !== 4'd0 || ctrl_vec() !== 23'd0 || bus.halted !== 1'b0 ||
        bus.instr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_values state=%0d ctrl=%h halted=%b cnt=%0d exp state=0 ctrl=0 halted=0 cnt=0",
               bus.state, ctrl_vec(), bus.halted, bus.instr_count);
    end
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.state !== 4'd0 || ctrl_vec() !== 23'd0) begin
      errors++;
      $display("FAIL idle_hold state=%0d ctrl=%h exp state=0 ctrl=0", bus.state, ctrl_vec());
    end
    bus.run = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1 || ctrl_vec() !== (M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
      errors++;
      $display("FAIL idle_to_t0 state=%0d ctrl=%h exp state=1 ctrl=%h",
               bus.state, ctrl_vec(), M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    end
  endtask

  task automatic test_ld();
    logic [22:0] exp_ld [0:8];
    exp_ld = '{M_PCOUT | M_MARIN | M_INCPC | M_ZIN, M_ZLOWOUT | M_PCIN, M_READ | M_MDRIN,
               M_MDROUT | M_IRIN, M_GRB | M_BAOUT | M_YIN, M_COUT | M_ADD | M_ZIN,
               M_ZLOWOUT | M_MARIN, M_READ | M_MDRIN, M_MDROUT | M_GRA | M_RIN};
    do_clear();
    bus.ir       = 32'h00800085;
    bus.run      = 1'b1;
    bus.mem_done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'(i + 1) || ctrl_vec() !== exp_ld[i]) begin
        errors++;
        $display("FAIL ld_step%0d state=%0d ctrl=%h exp state=%0d ctrl=%h",
                 i, bus.state, ctrl_vec(), i + 1, exp_ld[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1 || bus.instr_count !== 16'd1) begin
      errors++;
      $display("FAIL ld_retire state=%0d cnt=%0d exp state=1 cnt=1", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_mem_wait();
    do_clear();
    bus.ir  = 32'h00800085;
    bus.run = 1'b1;
    @(negedge clk);
    bus.mem_done = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd2) begin
      errors++;
      $display("FAIL stray_mem_done state=%0d exp=2", bus.state);
    end
    bus.mem_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd3 || ctrl_vec() !== (M_READ | M_MDRIN)) begin
        errors++;
        $display("FAIL t2_wait%0d state=%0d ctrl=%h exp state=3 ctrl=%h",
                 k, bus.state, ctrl_vec(), M_READ | M_MDRIN);
      end
      if (k == 3) bus.mem_done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd4) begin
      errors++;
      $display("FAIL t2_exit state=%0d exp=4", bus.state);
    end
  endtask

  task automatic test_add();
    do_clear();
    bus.ir       = 32'h18918000;
    bus.run      = 1'b1;
    bus.mem_done = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.state !== 4'd5 || ctrl_vec() !== (M_GRB | M_ROUT | M_YIN)) begin
      errors++;
      $display("FAIL add_t4 state=%0d ctrl=%h exp state=5 ctrl=%h",
               bus.state, ctrl_vec(), M_GRB | M_ROUT | M_YIN);
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd6 || ctrl_vec() !== (M_GRC | M_ROUT | M_ADD | M_ZIN)) begin
      errors++;
      $display("FAIL add_t5 state=%0d ctrl=%h exp state=6 ctrl=%h",
               bus.state, ctrl_vec(), M_GRC | M_ROUT | M_ADD | M_ZIN);
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd7 || ctrl_vec() !== (M_ZLOWOUT | M_GRA | M_RIN)) begin
      errors++;
      $display("FAIL add_t6 state=%0d ctrl=%h exp state=7 ctrl=%h",
               bus.state, ctrl_vec(), M_ZLOWOUT | M_GRA | M_RIN);
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1 || bus.instr_count !== 16'd1) begin
      errors++;
      $display("FAIL add_retire state=%0d cnt=%0d exp state=1 cnt=1", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] irs  [0:2];
    logic [22:0] sels [0:2];
    irs  = '{32'h20000000, 32'h28000000, 32'h30000000};
    sels = '{M_SUB, M_AND, M_OR};
    do_clear();
    bus.run      = 1'b1;
    bus.mem_done = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        if (c == 0) begin
          bus.ir  = irs[n];
          bus.run = 1'b0;
        end
        if (c == 5) begin
          checks++;
          if (bus.state !== 4'd6 || ctrl_vec() !== (M_GRC | M_ROUT | M_ZIN | sels[n])) begin
            errors++;
            $display("FAIL b2b_t5_op%0d state=%0d ctrl=%h exp state=6 ctrl=%h",
                     n, bus.state, ctrl_vec(), M_GRC | M_ROUT | M_ZIN | sels[n]);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1 || bus.instr_count !== 16'd3) begin
      errors++;
      $display("FAIL b2b_count state=%0d cnt=%0d exp state=1 cnt=3", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_st();
    do_clear();
    bus.ir       = 32'h10800085;
    bus.run      = 1'b1;
    bus.mem_done = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.state !== 4'd8 || ctrl_vec() !== (M_GRA | M_ROUT | M_MDRIN)) begin
      errors++;
      $display("FAIL st_t7 state=%0d ctrl=%h exp state=8 ctrl=%h",
               bus.state, ctrl_vec(), M_GRA | M_ROUT | M_MDRIN);
    end
    bus.mem_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd9 || ctrl_vec() !== M_WRITE) begin
        errors++;
        $display("FAIL st_t8_wait%0d state=%0d ctrl=%h exp state=9 ctrl=%h",
                 k, bus.state, ctrl_vec(), M_WRITE);
      end
    end
    bus.mem_done = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd1 || bus.instr_count !== 16'd1) begin
      errors++;
      $display("FAIL st_retire state=%0d cnt=%0d exp state=1 cnt=1", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_clear_mid();
    int  budget;
    do_clear();
    bus.ir       = 32'h00800085;
    bus.run      = 1'b1;
    bus.mem_done = 1'b1;
    budget       = 0;
    while (!(bus.state == 4'd8 && bus.instr_count == 16'd1) && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget >= 40) begin
      errors++;
      $display("FAIL clear_mid_reach state=%0d cnt=%0d exp state=8 cnt=1", bus.state, bus.instr_count);
    end
    bus.mem_done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd8 || ctrl_vec() !== (M_READ | M_MDRIN)) begin
      errors++;
      $display("FAIL ld_t7_wait state=%0d ctrl=%h exp state=8 ctrl=%h",
               bus.state, ctrl_vec(), M_READ | M_MDRIN);
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || ctrl_vec() !== 23'd0 || bus.instr_count !== 16'd0 ||
        bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL clear_async state=%0d ctrl=%h cnt=%0d halted=%b exp all 0",
               bus.state, ctrl_vec(), bus.instr_count, bus.halted);
    end
    @(negedge clk);
    clear   = 1'b0;
    bus.run = 1'b0;
  endtask

  task automatic test_halt(input logic [31:0] ir_val);
    do_clear();
    bus.ir       = ir_val;
    bus.run      = 1'b1;
    bus.mem_done = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.state !== 4'd4 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_t3 ir=%h state=%0d halted=%b exp state=4 halted=0",
               ir_val, bus.state, bus.halted);
    end
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd10 || bus.halted !== 1'b1 || ctrl_vec() !== 23'd0) begin
        errors++;
        $display("FAIL halt_hold%0d ir=%h state=%0d halted=%b ctrl=%h exp state=10 halted=1 ctrl=0",
                 k, ir_val, bus.state, bus.halted, ctrl_vec());
      end
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    clear        = 1'b1;
    bus.run      = 1'b0;
    bus.ir       = 32'h0;
    bus.mem_done = 1'b0;
    test_reset();
    test_ld();
    test_mem_wait();
    test_add();
    test_back_to_back();
    test_st();
    test_clear_mid();
    test_halt(32'hD8000000);
    test_halt(32'h38000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
